// File: rtl/fc_gate_counter.sv
// Gated multi-channel frequency counter with a small byte-wide register file.
// Each channel counts synchronised rising edges over a programmable gate of
// G * 2^PRE_W clk cycles and publishes the totals in RESULT registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START
// S_ARM   | one cycle: clear counters/prescaler, load gate length
// S_GATE  | counting edges until the gate expires
// S_LATCH | one cycle: publish results, set DONE/OVF, rearm if CONT
module fc_gate_counter #(
    parameter int CH    = 2,
    parameter int CNT_W = 24,
    parameter int PRE_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sig_in,
    input  logic [3:0]    mem_addr,
    input  logic [7:0]    mem_dout,
    input  logic          mem_wrt,
    output logic [7:0]    mem_din,
    output logic          busy,
    output logic          irq
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_LATCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic             cont_q;
    logic             done_q;
    logic             ovf_q;
    logic [7:0]       gate_l_q;
    logic [7:0]       gate_h_q;
    logic [CH-1:0]    sync1_q, sync2_q, sync3_q;
    logic [CH-1:0]    sat_q;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] res_q [CH];
    logic [PRE_W-1:0] pre_q;
    logic [15:0]      gate_rem_q;

    logic          wr_ctrl, wr_stat, start_w, abort_w, clr_w;
    logic          tick_w, last_w;
    logic [CH-1:0] edge_w;
    logic [15:0]   gate_len;
    logic [31:0]   res32;

    assign wr_ctrl  = mem_wrt && (mem_addr == 4'd0);
    assign wr_stat  = mem_wrt && (mem_addr == 4'd1);
    assign start_w  = wr_ctrl && mem_dout[0];
    assign abort_w  = wr_ctrl && mem_dout[2];
    assign clr_w    = wr_stat && mem_dout[0];
    assign edge_w   = sync2_q & ~sync3_q;
    assign tick_w   = &pre_q;
    assign last_w   = tick_w && (gate_rem_q == 16'd1);
    // A zero gate length would never expire, so it runs as one tick.
    assign gate_len = ({gate_h_q, gate_l_q} == 16'd0) ? 16'd1 : {gate_h_q, gate_l_q};

    assign busy = (state_q != S_IDLE);
    assign irq  = done_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort only matters while arming or gating.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_w) state_d = S_ARM;
            S_ARM:   state_d = abort_w ? S_IDLE : S_GATE;
            S_GATE:  begin
                if (abort_w)     state_d = S_IDLE;
                else if (last_w) state_d = S_LATCH;
            end
            S_LATCH: state_d = cont_q ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Two-flop synchronisers plus an edge-detect stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Gate timing and saturating per-channel edge counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            gate_rem_q <= '0;
            sat_q      <= '0;
            for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
        end else if (state_q == S_ARM) begin
            pre_q      <= '0;
            gate_rem_q <= gate_len;
            sat_q      <= '0;
            for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
        end else if (state_q == S_GATE) begin
            pre_q <= pre_q + 1'b1;
            if (tick_w) gate_rem_q <= gate_rem_q - 16'd1;
            for (int c = 0; c < CH; c++) begin
                if (edge_w[c]) begin
                    if (cnt_q[c] == CNT_MAX) sat_q[c] <= 1'b1;
                    else                     cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // Result registers only move on LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) res_q[c] <= '0;
        end else if (state_q == S_LATCH) begin
            for (int c = 0; c < CH; c++) res_q[c] <= cnt_q[c];
        end
    end

    // Status flags; a LATCH in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == S_LATCH) begin
            done_q <= 1'b1;
            ovf_q  <= (clr_w ? 1'b0 : ovf_q) | (|sat_q);
        end else if (clr_w) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end
    end

    // Writable configuration: CONT and gate length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q   <= 1'b0;
            gate_l_q <= '0;
            gate_h_q <= '0;
        end else if (mem_wrt) begin
            case (mem_addr)
                4'd0:    cont_q   <= mem_dout[1];
                4'd2:    gate_l_q <= mem_dout;
                4'd3:    gate_h_q <= mem_dout;
                default: ;
            endcase
        end
    end

    // Combinational read mux; RESULT bytes come from zero-extended counts.
    always_comb begin
        mem_din = 8'h00;
        res32   = '0;
        case (mem_addr)
            4'd0:    mem_din = {busy, 5'b0, cont_q, 1'b0};
            4'd1:    mem_din = {6'b0, ovf_q, done_q};
            4'd2:    mem_din = gate_l_q;
            4'd3:    mem_din = gate_h_q;
            default: begin
                for (int c = 0; c < CH; c++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_addr == 4'(4 + 4 * c + b)) begin
                            res32   = 32'(res_q[c]);
                            mem_din = res32[8*b +: 8];
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fc_gate_counter.sv
// Directed bench for fc_gate_counter with CH=2, CNT_W=8, PRE_W=2.
module tb_fc_gate_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sig_in;
    logic [3:0] mem_addr;
    logic [7:0] mem_dout;
    logic       mem_wrt;
    logic [7:0] mem_din;
    logic       busy;
    logic       irq;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] d;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    int         div = 0;

    fc_gate_counter #(.CH(2), .CNT_W(8), .PRE_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_wrt  (mem_wrt),
        .mem_din  (mem_din),
        .busy     (busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ch0 toggles every 2 cycles (clk/4), ch1 every cycle (clk/2).
    always @(negedge clk) begin
        div = div + 1;
        sig_in[0] = en0 & div[1];
        sig_in[1] = en1 & div[0];
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        mem_addr = a;
        mem_dout = v;
        mem_wrt  = 1'b1;
        @(negedge clk);
        mem_wrt  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        mem_addr = a;
        #1;
        v = mem_din;
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
        end
        @(negedge clk);
    endtask

    task automatic test_regs();
        wr(4'd2, 8'hA5);
        wr(4'd3, 8'h3C);
        wr(4'd15, 8'hFF);
        rd(4'd2, d);
        n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL regs_gate_l: got %h want a5", d); end
        rd(4'd3, d);
        n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL regs_gate_h: got %h want 3c", d); end
        rd(4'd15, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL regs_unmapped_f: got %h want 00", d); end
        rd(4'd12, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL regs_unmapped_c: got %h want 00", d); end
        @(negedge clk);
        wr(4'd0, 8'h02);
        rd(4'd0, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL regs_ctrl_cont: got %h want 02", d); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL regs_cont_nostart: got %b want 0", busy); end
        @(negedge clk);
        wr(4'd0, 8'h00);
        rd(4'd0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL regs_ctrl_clr: got %h want 00", d); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        wr(4'd2, 8'd5);
        wr(4'd3, 8'd0);
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h01);
        mem_addr = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                n_cmp++; if (mem_din !== 8'h80) begin n_bad++; $display("FAIL single_ctrl_busy: got %h want 80", mem_din); end
            end
            @(negedge clk);
        end
        n_cmp++; if (n !== 22) begin n_bad++; $display("FAIL single_busy_len: got %0d want 22", n); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL single_irq: got %b want 1", irq); end
        rd(4'd1, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL single_status: got %h want 01", d); end
        rd(4'd4, d);
        n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL single_ch0_b0: got %h want 05", d); end
        for (int b = 5; b < 12; b++) begin
            rd(4'(b), d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL single_res_%0d: got %h want 00", b, d); end
        end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int n;
        en1 = 1'b1;
        wr(4'd2, 8'd200);
        wr(4'd3, 8'd0);
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h01);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
        n_cmp++; if (n !== 802) begin n_bad++; $display("FAIL sat_busy_len: got %0d want 802", n); end
        rd(4'd8, d);
        n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL sat_ch1_b0: got %h want ff", d); end
        rd(4'd9, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL sat_ch1_b1: got %h want 00", d); end
        rd(4'd11, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL sat_ch1_b3: got %h want 00", d); end
        rd(4'd4, d);
        n_cmp++; if (d !== 8'hC8) begin n_bad++; $display("FAIL sat_ch0_b0: got %h want c8", d); end
        rd(4'd1, d);
        n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL sat_status: got %h want 03", d); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h01);
        repeat (3) @(negedge clk);
        wr(4'd0, 8'h04);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL abort_irq: got %b want 0", irq); end
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_late: got %b want 0", busy); end
        rd(4'd1, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL abort_status: got %h want 00", d); end
        rd(4'd4, d);
        n_cmp++; if (d !== 8'hC8) begin n_bad++; $display("FAIL abort_ch0_held: got %h want c8", d); end
        rd(4'd8, d);
        n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL abort_ch1_held: got %h want ff", d); end
        @(negedge clk);
    endtask

    task automatic test_cont();
        int nb, nl;
        wr(4'd2, 8'd1);
        wr(4'd3, 8'd0);
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h03);
        nb = 0;
        nl = 0;
        // Clear DONE every cycle so each LATCH shows as a single irq cycle.
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) nb++;
            if (irq === 1'b1) nl++;
            mem_addr = (i == 19) ? 4'd0 : 4'd1;
            mem_dout = (i == 19) ? 8'h00 : 8'h01;
            mem_wrt  = 1'b1;
            @(negedge clk);
        end
        mem_wrt = 1'b0;
        n_cmp++; if (nl !== 4) begin n_bad++; $display("FAIL cont_latches: got %0d want 4", nl); end
        n_cmp++; if (nb !== 24) begin n_bad++; $display("FAIL cont_busy_len: got %0d want 24", nb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_idle: got %b want 0", busy); end
        rd(4'd0, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL cont_ctrl: got %h want 00", d); end
        @(negedge clk);
    endtask

    task automatic test_zero_gate();
        int n;
        wr(4'd2, 8'd0);
        wr(4'd3, 8'd0);
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h01);
        n = 0;
        repeat (5) begin if (busy === 1'b1) n++; @(negedge clk); end
        if (busy === 1'b1) n++;
        wr(4'd1, 8'h01);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL zero_busy_len: got %0d want 6", n); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle: got %b want 0", busy); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL zero_clr_vs_set: got %b want 1", irq); end
        rd(4'd1, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL zero_status: got %h want 01", d); end
        rd(4'd4, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL zero_ch0: got %h want 01", d); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        wr(4'd2, 8'd5);
        wr(4'd3, 8'd0);
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h01);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
        mem_addr = 4'd1;
        #0.5;
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rstmid_status: got %h want 00", mem_din); end
        for (int a = 4; a < 12; a++) begin
            rd(4'(a), d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_res_%0d: got %h want 00", a, d); end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(4'd2, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_gate_l: got %h want 00", d); end
        @(negedge clk);
        wr(4'd0, 8'h01);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL rstmid_rerun_len: got %0d want 6", n); end
        rd(4'd4, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL rstmid_rerun_ch0: got %h want 01", d); end
        rd(4'd1, d);
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL rstmid_rerun_status: got %h want 01", d); end
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        sig_in   = 2'b00;
        mem_addr = 4'd0;
        mem_dout = 8'h00;
        mem_wrt  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        en0 = 1'b1;
        test_regs();
        repeat (4) @(negedge clk);
        test_single();
        test_saturate();
        test_abort();
        test_cont();
        test_zero_gate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
